lsu_ctrl: RTL

//  Load/store controller between the MIPS datapath and the word-addressed data memory (dmem).

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 72 +++++++
 rtl/lsu_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//   Shared encodings for the load/store unit: access size codes, FSM state
//   codes and a small alignment helper used when a request is accepted.
// ----------------------------------------------------------------------------
package lsu_pkg;

  // Access size encodings as driven by the datapath on `size`.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Controller FSM state encodings.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] WRITE  = 2'b10;
  localparam logic [1:0] RESP   = 2'b11;

  // True when the size code is illegal or the low address bits do not match
  // the natural alignment of the access.
  function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = lane[0];
      SZ_WORD: bad_align = (lane != 2'b00);
      default: bad_align = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
//   Purely combinational byte-lane steering for the load/store unit.
//   extracted : sub-word of `word` at byte lane `lane`, sign- or zero-extended
//   merged    : `word` with the byte/half at `lane` replaced by the low bits
//               of `wdata` (full `wdata` for word accesses)
// Ports
//   word      in  32  memory word being read
//   wdata     in  32  store data (low byte/half used for sub-word stores)
//   lane      in   2  byte offset within the word (little-endian lanes)
//   size      in   2  SZ_BYTE / SZ_HALF / SZ_WORD
//   sext      in   1  1 = sign-extend extracted sub-words
//   extracted out 32  load result
//   merged    out 32  read-modify-write result
// ----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output of a combinational block gets a default assignment
  // first so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    byte_v = word[7:0];
    case (lane)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];

    extracted = word;
    case (size)
      SZ_BYTE: extracted = {{24{sext & byte_v[7]}}, byte_v};
      SZ_HALF: extracted = {{16{sext & half_v[15]}}, half_v};
      default: extracted = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_ctrl
//   Load/store controller between the datapath and a word-addressed data
//   memory. Sub-word stores are done as read-modify-write; sub-word loads are
//   extracted and extended. Misaligned, out-of-range and illegal-size
//   requests are answered with fault and never touch memory.
// Parameters
//   MEM_WORDS  words in dmem; legal byte addresses 0 .. MEM_WORDS*4-1
// Ports
//   clk      in   1   clock, all state updates on posedge
//   reset_n  in   1   asynchronous active-low reset
//   req      in   1   access request, sampled only in IDLE
//   wr       in   1   1 = store, 0 = load
//   size     in   2   00 byte, 01 half, 10 word, 11 illegal
//   sext     in   1   loads: 1 = sign-extend
//   addr     in  32   byte address
//   wdata    in  32   store data
//   busy     out  1   high while not IDLE
//   done     out  1   one-cycle completion pulse
//   fault    out  1   valid with done
//   rdata    out 32   registered load result
//   mem_a    out 32   dmem word address (byte address, low bits zero)
//   mem_wd   out 32   dmem write data
//   mem_we   out  1   dmem write enable
//   mem_rd   in  32   dmem combinational read data
// ----------------------------------------------------------------------------
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  // One past the last legal byte address; 33 bits so large MEM_WORDS cannot wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [1:0]  state;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        req_fault;
  logic [31:0] extracted;
  logic [31:0] merged;

  // Fault decision uses the live request so the FSM can skip ACCESS entirely.
  assign req_fault = bad_align(size, addr[1:0]) || ({1'b0, addr} >= ADDR_LIMIT);

  lsu_align u_align (
    .word      (mem_rd),
    .wdata     (wdata_q),
    .lane      (addr_q[1:0]),
    .size      (size_q),
    .sext      (sext_q),
    .extracted (extracted),
    .merged    (merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            wr_q    <= wr;
            size_q  <= size;
            sext_q  <= sext;
            addr_q  <= addr;
            wdata_q <= wdata;
            fault_q <= req_fault;
            state   <= req_fault ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!wr_q) begin
            rdata_q <= extracted;
            state   <= RESP;
          end else if (size_q == SZ_WORD) begin
            state   <= RESP;
          end else begin
            merge_q <= merged;
            state   <= WRITE;
          end
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == RESP);
  assign fault  = (state == RESP) && fault_q;
  assign rdata  = rdata_q;
  assign mem_a  = {addr_q[31:2], 2'b00};
  // Selected by the latched size rather than the state so the value does not
  // switch source between ACCESS and WRITE.
  assign mem_wd = (size_q == SZ_WORD) ? wdata_q : merge_q;
  // A full-word store writes from ACCESS; sub-word stores only from WRITE.
  // Exactly one cycle ever writes, so a reset can never leave a torn word.
  assign mem_we = ((state == ACCESS) && wr_q && (size_q == SZ_WORD)) ||
                  (state == WRITE);

endmodule
